dp_acc_unit: RTL and testbench

- Parametrised successor to the fixed 4-lane 8-bit dot-product unit.
- Computes an N_MUL-lane dot product of packed operand vectors through a fully pipelined multiplier array and a log2 adder tree.
- Accumulates per-beat partial sums across a multi-beat vector, marked by in_last, and emits one result per vector with a valid strobe.
- Adds per-beat signed/unsigned mode, optional saturation with overflow flag, and a global stall (enable). Sits inside the PE array as the MAC datapath.

---
 rtl/dp_acc_unit.sv | 182 ++++++++++++++++++
 tb/tb_dp_acc_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_acc_unit.sv
// dp_acc_unit: pipelined N_MUL-lane dot-product MAC datapath.
//
// A beat (in_a/in_b, N_MUL lanes of DW_MUL bits) is registered, multiplied
// lane-wise, reduced through a registered binary adder tree and accumulated
// until the beat tagged in_last, which emits one result with a valid strobe.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   enable     pipeline advance; 0 freezes every stage and the outputs
//   in_valid   beat present on in_a/in_b
//   in_last    beat closes the current vector (qualified by in_valid)
//   in_signed  1 = lanes are two's complement, 0 = unsigned (per beat)
//   in_a/in_b  packed operands, lane k at [k*DW_MUL +: DW_MUL]
//   out        signed vector result, held between strobes
//   out_valid  one-cycle strobe per completed vector
//   out_ovf    overflow/saturation seen during this vector
module dp_acc_unit #(
  parameter int unsigned N_MUL  = 4,
  parameter int unsigned DW_MUL = 8,
  parameter int unsigned DW_ACC = 32,
  parameter int unsigned SAT    = 1,
  parameter int unsigned DW_IN  = DW_MUL * N_MUL
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic              in_signed,
  input  logic [DW_IN-1:0]  in_a,
  input  logic [DW_IN-1:0]  in_b,
  output logic [DW_ACC-1:0] out,
  output logic              out_valid,
  output logic              out_ovf
);

  localparam int unsigned LOG2N = $clog2(N_MUL);
  localparam int unsigned PW    = 2 * DW_MUL + 1;   // lane product width
  localparam int unsigned TW    = PW + LOG2N;       // tree result width
  // Sum width covers both operands plus a carry, so overflow is detected
  // exactly even when the tree result is wider than the accumulator.
  localparam int unsigned SW    = ((DW_ACC > TW) ? DW_ACC : TW) + 1;

  localparam logic signed [SW-1:0] AccMax = SW'({1'b0, {(DW_ACC - 1){1'b1}}});
  localparam logic signed [SW-1:0] AccMin = ~AccMax;

  // Extend each operand by one bit (sign or zero) so one signed multiplier
  // serves both modes; the true product always fits in PW bits.
  function automatic logic signed [PW-1:0] mul_lane(input logic [DW_MUL-1:0] a,
                                                    input logic [DW_MUL-1:0] b,
                                                    input logic              sgn);
    logic signed [DW_MUL:0] a_x;
    logic signed [DW_MUL:0] b_x;
    a_x = {sgn & a[DW_MUL-1], a};
    b_x = {sgn & b[DW_MUL-1], b};
    return PW'(a_x) * PW'(b_x);
  endfunction

  // ---------------------------------------------------------------------------
  // S0: input register
  // ---------------------------------------------------------------------------
  logic [DW_IN-1:0] a_s0_q, b_s0_q;
  logic             vld_s0_q, lst_s0_q, sgn_s0_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_s0_q   <= '0;
      b_s0_q   <= '0;
      vld_s0_q <= 1'b0;
      lst_s0_q <= 1'b0;
      sgn_s0_q <= 1'b0;
    end else if (enable) begin
      a_s0_q   <= in_a;
      b_s0_q   <= in_b;
      vld_s0_q <= in_valid;
      lst_s0_q <= in_last;
      sgn_s0_q <= in_signed;
    end
  end

  // ---------------------------------------------------------------------------
  // Level 0 = multiplier stage, levels 1..LOG2N = adder tree, one register
  // stage each. Level l holds N_MUL>>l nodes of PW+l bits.
  // ---------------------------------------------------------------------------
  for (genvar l = 0; l <= LOG2N; l++) begin : g_lvl
    localparam int unsigned W  = PW + l;
    localparam int unsigned NN = N_MUL >> l;

    logic signed [W-1:0] node_d [NN];
    logic signed [W-1:0] node_q [NN];
    logic                vld_in, lst_in;
    logic                vld_q, lst_q;

    if (l == 0) begin : g_mul
      assign vld_in = vld_s0_q;
      assign lst_in = lst_s0_q;
      always_comb begin
        for (int k = 0; k < N_MUL; k++) begin
          node_d[k] = mul_lane(a_s0_q[k*DW_MUL +: DW_MUL], b_s0_q[k*DW_MUL +: DW_MUL],
                               sgn_s0_q);
        end
      end
    end else begin : g_add
      assign vld_in = g_lvl[l-1].vld_q;
      assign lst_in = g_lvl[l-1].lst_q;
      always_comb begin
        for (int j = 0; j < NN; j++) begin
          node_d[j] = W'(g_lvl[l-1].node_q[2*j]) + W'(g_lvl[l-1].node_q[2*j+1]);
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        node_q <= '{default: '0};
        vld_q  <= 1'b0;
        lst_q  <= 1'b0;
      end else if (enable) begin
        node_q <= node_d;
        vld_q  <= vld_in;
        lst_q  <= lst_in;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulate stage
  // ---------------------------------------------------------------------------
  logic signed [TW-1:0]     tree_res;
  logic                     tree_vld, tree_lst;
  logic signed [DW_ACC-1:0] acc_q;
  logic                     ovf_q;
  logic [DW_ACC-1:0]        out_q;
  logic                     out_valid_q, out_ovf_q;
  logic signed [SW-1:0]     sum_w;
  logic signed [DW_ACC-1:0] res;
  logic                     this_ovf;

  assign tree_res = g_lvl[LOG2N].node_q[0];
  assign tree_vld = g_lvl[LOG2N].vld_q;
  assign tree_lst = g_lvl[LOG2N].lst_q;

  always_comb begin
    sum_w    = SW'(acc_q) + SW'(tree_res);
    this_ovf = (sum_w > AccMax) || (sum_w < AccMin);
    res      = sum_w[DW_ACC-1:0];
    // Saturated value is also what the accumulator continues from.
    if (this_ovf && (SAT != 0)) begin
      res = sum_w[SW-1] ? AccMin[DW_ACC-1:0] : AccMax[DW_ACC-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else if (enable) begin
      out_valid_q <= 1'b0;
      if (tree_vld) begin
        if (tree_lst) begin
          out_q       <= res;
          out_valid_q <= 1'b1;
          out_ovf_q   <= ovf_q | this_ovf;
          acc_q       <= '0;
          ovf_q       <= 1'b0;
        end else begin
          acc_q <= res;
          ovf_q <= ovf_q | this_ovf;
        end
      end
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_dp_acc_unit.sv
// Bench for dp_acc_unit: a 32-bit-accumulator instance and an 18-bit one
// (saturating) share stimulus. A behavioural model computes each vector's
// result with plain integer arithmetic and schedules its strobe L enabled
// cycles after the closing beat; outputs are checked every cycle.
module tb_dp_acc_unit;

  localparam int unsigned L = 5;

  logic        clk = 1'b0;
  logic        reset_n, enable, in_valid, in_last, in_signed;
  logic [31:0] in_a, in_b;
  logic [31:0] out32;
  logic        v32, ovf32;
  logic [17:0] out18;
  logic        v18, ovf18;

  always #5 clk = ~clk;

  dp_acc_unit #(.N_MUL(4), .DW_MUL(8), .DW_ACC(32), .SAT(1)) u_dut32 (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_signed(in_signed),
    .in_a     (in_a),
    .in_b     (in_b),
    .out      (out32),
    .out_valid(v32),
    .out_ovf  (ovf32)
  );

  dp_acc_unit #(.N_MUL(4), .DW_MUL(8), .DW_ACC(18), .SAT(1)) u_dut18 (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_signed(in_signed),
    .in_a     (in_a),
    .in_b     (in_b),
    .out      (out18),
    .out_valid(v18),
    .out_ovf  (ovf18)
  );

  typedef struct {
    int unsigned idx;
    longint      val;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    longint      e32;
    longint      e18;
    logic        ovf18;
  } vec_t;

  exp_t        expq0[$];
  exp_t        expq1[$];
  longint      acc_m[2];
  logic        ovf_m[2];
  logic        ev[2];
  longint      eo[2];
  logic        eovf[2];
  int unsigned ecount;
  int          n_cmp;
  int          n_bad;
  vec_t        tbl[8];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint dot(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint s;
    longint x;
    longint y;
    s = 0;
    for (int k = 0; k < 4; k++) begin
      x = sgn ? longint'($signed(a[k*8 +: 8])) : longint'(a[k*8 +: 8]);
      y = sgn ? longint'($signed(b[k*8 +: 8])) : longint'(b[k*8 +: 8]);
      s += x * y;
    end
    return s;
  endfunction

  task automatic model_beat(input logic lst, input longint d);
    longint mx;
    longint mn;
    longint s;
    logic   ov;
    exp_t   e;
    for (int i = 0; i < 2; i++) begin
      mx = (longint'(1) <<< ((i == 0) ? 31 : 17)) - 1;
      mn = -mx - 1;
      s  = acc_m[i] + d;
      ov = 1'b0;
      if (s > mx) begin
        s  = mx;
        ov = 1'b1;
      end else if (s < mn) begin
        s  = mn;
        ov = 1'b1;
      end
      if (lst) begin
        e.idx = ecount + L - 1;
        e.val = s;
        e.ovf = ovf_m[i] | ov;
        if (i == 0) expq0.push_back(e);
        else        expq1.push_back(e);
        acc_m[i] = 0;
        ovf_m[i] = 1'b0;
      end else begin
        acc_m[i] = s;
        ovf_m[i] = ovf_m[i] | ov;
      end
    end
  endtask

  task automatic check_outs(input logic en);
    longint act_o[2];
    logic   act_v[2];
    logic   act_f[2];
    act_o[0] = longint'($signed(out32));
    act_o[1] = longint'($signed(out18));
    act_v[0] = v32;
    act_v[1] = v18;
    act_f[0] = ovf32;
    act_f[1] = ovf18;
    if (en) begin
      ev[0] = 1'b0;
      ev[1] = 1'b0;
      if (expq0.size() > 0 && expq0[0].idx == ecount) begin
        ev[0]   = 1'b1;
        eo[0]   = expq0[0].val;
        eovf[0] = expq0[0].ovf;
        void'(expq0.pop_front());
      end
      if (expq1.size() > 0 && expq1[0].idx == ecount) begin
        ev[1]   = 1'b1;
        eo[1]   = expq1[0].val;
        eovf[1] = expq1[0].ovf;
        void'(expq1.pop_front());
      end
    end
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("out_valid[dut%0d]", i), longint'(act_v[i]), longint'(ev[i]));
      chk($sformatf("out[dut%0d]", i), act_o[i], eo[i]);
      chk($sformatf("out_ovf[dut%0d]", i), longint'(act_f[i]), longint'(eovf[i]));
    end
  endtask

  task automatic tick(input logic en, input logic vld, input logic lst, input logic sgn,
                      input logic [31:0] a, input logic [31:0] b);
    enable    = en;
    in_valid  = vld;
    in_last   = lst;
    in_signed = sgn;
    in_a      = a;
    in_b      = b;
    @(posedge clk);
    #1;
    if (en) begin
      ecount++;
      if (vld) model_beat(lst, dot(a, b, sgn));
    end
    check_outs(en);
  endtask

  task automatic idle();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Idles until the 32-bit instance strobes, then compares against constants.
  task automatic wait_strobe(input string name, input longint e32, input longint e18,
                             input logic eo18);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 12 && !got; n++) begin
      idle();
      if (v32) begin
        got = 1'b1;
        chk({name, "_out32"}, longint'($signed(out32)), e32);
        chk({name, "_out18"}, longint'($signed(out18)), e18);
        chk({name, "_ovf32"}, longint'(ovf32), 0);
        chk({name, "_ovf18"}, longint'(ovf18), longint'(eo18));
      end
    end
    if (!got) chk({name, "_strobe_timeout"}, 0, 1);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #2;
    chk("rst_out32", longint'(out32), 0);
    chk("rst_valid32", longint'(v32), 0);
    chk("rst_ovf32", longint'(ovf32), 0);
    chk("rst_out18", longint'(out18), 0);
    chk("rst_valid18", longint'(v18), 0);
    chk("rst_ovf18", longint'(ovf18), 0);
    reset_n = 1'b1;
    expq0.delete();
    expq1.delete();
    for (int i = 0; i < 2; i++) begin
      acc_m[i] = 0;
      ovf_m[i] = 1'b0;
      ev[i]    = 1'b0;
      eo[i]    = 0;
      eovf[i]  = 1'b0;
    end
  endtask

  initial begin
    int first;
    int cnt;
    int last_i;
    n_cmp  = 0;
    n_bad  = 0;
    ecount = 0;

    //           a             b             sgn   e32      e18     ovf18
    tbl[0] = '{32'h04030201, 32'h08070605, 1'b1, 70,      70,     1'b0};
    tbl[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 260100,  131071, 1'b1};
    tbl[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 4,       4,      1'b0};
    tbl[3] = '{32'h80808080, 32'h80808080, 1'b1, 65536,   65536,  1'b0};
    tbl[4] = '{32'h7F7F7F7F, 32'h80808080, 1'b1, -65024,  -65024, 1'b0};
    tbl[5] = '{32'h00000000, 32'hFFFFFFFF, 1'b1, 0,       0,      1'b0};
    tbl[6] = '{32'h80FF017F, 32'h02030405, 1'b1, 380,     380,    1'b0};
    tbl[7] = '{32'h80FF017F, 32'h02030405, 1'b0, 1660,    1660,   1'b0};

    reset_n   = 1'b0;
    enable    = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_signed = 1'b0;
    in_a      = '0;
    in_b      = '0;
    for (int i = 0; i < 2; i++) begin
      acc_m[i] = 0;
      ovf_m[i] = 1'b0;
      ev[i]    = 1'b0;
      eo[i]    = 0;
      eovf[i]  = 1'b0;
    end
    #3;
    chk("reset_out32", longint'(out32), 0);
    chk("reset_valid32", longint'(v32), 0);
    chk("reset_ovf32", longint'(ovf32), 0);
    chk("reset_out18", longint'(out18), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Single-beat vectors from the table.
    foreach (tbl[i]) begin
      tick(1'b1, 1'b1, 1'b1, tbl[i].sgn, tbl[i].a, tbl[i].b);
      wait_strobe($sformatf("tbl%0d", i), tbl[i].e32, tbl[i].e18, tbl[i].ovf18);
    end

    // Single beat: strobe exactly L cycles after the beat.
    tick(1'b1, 1'b1, 1'b1, 1'b1, 32'h04030201, 32'h08070605);
    first = 0;
    for (int n = 2; n <= 10; n++) begin
      idle();
      if (v32 && first == 0) first = n;
    end
    chk("latency", first, L);

    // Three beats with a bubble before the third.
    tick(1'b1, 1'b1, 1'b0, 1'b1, 32'h80808080, 32'h80808080);
    tick(1'b1, 1'b1, 1'b0, 1'b1, 32'h80808080, 32'h80808080);
    idle();
    tick(1'b1, 1'b1, 1'b1, 1'b1, 32'h80808080, 32'h80808080);
    wait_strobe("bubble3", 196608, 131071, 1'b1);

    // Saturation then a fresh vector starting from zero.
    tick(1'b1, 1'b1, 1'b0, 1'b1, 32'h7F7F7F7F, 32'h7F7F7F7F);
    tick(1'b1, 1'b1, 1'b0, 1'b1, 32'h7F7F7F7F, 32'h7F7F7F7F);
    tick(1'b1, 1'b1, 1'b1, 1'b1, 32'h7F7F7F7F, 32'h7F7F7F7F);
    wait_strobe("sat", 193548, 131071, 1'b1);
    tick(1'b1, 1'b1, 1'b1, 1'b1, 32'h01010101, 32'h01010101);
    wait_strobe("sat_next", 4, 4, 1'b0);

    // Three-cycle stall mid-pipeline delays the strobe by exactly three.
    first = 0;
    for (int n = 1; n <= 14; n++) begin
      tick(!(n >= 3 && n <= 5), n == 1, 1'b1, 1'b1, 32'h04030201, 32'h08070605);
      if (v32 && first == 0) first = n;
    end
    chk("stall_latency", first, L + 3);
    chk("stall_value", longint'($signed(out32)), 70);

    // A strobe present when enable drops stays up until the next enabled edge.
    tick(1'b1, 1'b1, 1'b1, 1'b0, 32'h00000302, 32'h00000504);
    for (int n = 0; n < 4; n++) idle();
    chk("strobe_before_stall", longint'(v32), 1);
    tick(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h12345678);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h87654321, 32'hFFFFFFFF);
    chk("strobe_held", longint'(v32), 1);
    chk("strobe_held_val", longint'($signed(out32)), 2 * 4 + 3 * 5);
    idle();
    chk("strobe_drop", longint'(v32), 0);

    // Reset mid-vector discards the partial sum.
    tick(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    pulse_reset();
    tick(1'b1, 1'b1, 1'b1, 1'b1, 32'h04030201, 32'h08070605);
    wait_strobe("post_reset", 70, 70, 1'b0);

    // Eight back-to-back single-beat vectors: eight consecutive strobes.
    cnt    = 0;
    first  = 0;
    last_i = 0;
    for (int n = 1; n <= 20; n++) begin
      tick(1'b1, n <= 8, 1'b1, 1'($urandom), $urandom, $urandom);
      if (v32) begin
        cnt++;
        if (first == 0) first = n;
        last_i = n;
      end
    end
    chk("b2b_count", cnt, 8);
    chk("b2b_span", last_i - first + 1, 8);

    // Randomised traffic with stalls, bubbles, mixed modes and one reset.
    for (int n = 0; n < 400; n++) begin
      if (n == 200) pulse_reset();
      tick($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           1'($urandom), $urandom, $urandom);
    end
    for (int n = 0; n < 12; n++) idle();
    chk("drain32", expq0.size(), 0);
    chk("drain18", expq1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
